// File: rtl/piso_serializer_if.sv
// Load-side handshake and serial output bundle for piso_serializer.
// The master modport is the word producer; the slave modport is the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clken;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             SO;
  logic             so_valid;
  logic             done;

  modport master (
    output clken,
    output load_data,
    output load_valid,
    input  load_ready,
    input  SO,
    input  so_valid,
    input  done
  );

  modport slave (
    input  clken,
    input  load_data,
    input  load_valid,
    output load_ready,
    output SO,
    output so_valid,
    output done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-entry holding register and gap-free framing.
// Define PISO_SERIALIZER_LSB_FIRST_EN to transmit LSB first; the default build is MSB first.
module piso_serializer #(
  parameter int unsigned WIDTH = 8  // legal range 2..32
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             handshake;
  logic             last_bit;
  logic             transfer;
  logic [WIDTH-1:0] shreg_shifted;
  logic             out_bit;

`ifdef PISO_SERIALIZER_LSB_FIRST_EN
  assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
  assign out_bit       = shreg_q[0];
`else
  assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
  assign out_bit       = shreg_q[WIDTH-1];
`endif

  // Handshake depends only on the registered flag so load_ready never sees clken.
  assign handshake = bus.load_valid && !hold_full_q;
  assign last_bit  = (state_q == StShift) && bus.clken && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    transfer    = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.clken && hold_full_q) begin
          transfer = 1'b1;
        end
      end
      StShift: begin
        if (last_bit) begin
          if (hold_full_q) begin
            transfer = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (bus.clken) begin
          shreg_d = shreg_shifted;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (transfer) begin
      state_d     = StShift;
      shreg_d     = hold_q;
      hold_full_d = 1'b0;
      cnt_d       = '0;
    end

    // Handshake and transfer are exclusive: one needs hold empty, the other hold full.
    if (handshake) begin
      hold_d      = bus.load_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.load_ready = !hold_full_q;
  assign bus.so_valid   = (state_q == StShift);
  assign bus.SO         = (state_q == StShift) && out_bit;
  assign bus.done       = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer at WIDTH=8, either bit-order build.
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_LSB_FIRST_EN
  localparam logic [7:0] SeqA5 = 8'hA5;
  localparam logic [7:0] Seq01 = 8'h80;
  localparam logic [7:0] SeqF0 = 8'h0F;
  localparam logic [7:0] Seq0F = 8'hF0;
  localparam logic [7:0] Seq81 = 8'h81;
  localparam logic [7:0] Seq3C = 8'h3C;
`else
  localparam logic [7:0] SeqA5 = 8'hA5;
  localparam logic [7:0] Seq01 = 8'h01;
  localparam logic [7:0] SeqF0 = 8'hF0;
  localparam logic [7:0] Seq0F = 8'h0F;
  localparam logic [7:0] Seq81 = 8'h81;
  localparam logic [7:0] Seq3C = 8'h3C;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus ();

  piso_serializer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.SO, bus.so_valid, bus.done, bus.load_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_outputs: got SO/so_valid/done/load_ready=%b want 0001",
               {bus.SO, bus.so_valid, bus.done, bus.load_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.so_valid, bus.load_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_release: got so_valid/load_ready=%b want 01",
               {bus.so_valid, bus.load_ready});
    end
  endtask

  task automatic test_basic();
    logic [7:0] words [2];
    logic [7:0] seqs [2];
    logic [7:0] seq;
    words[0] = 8'hA5; seqs[0] = SeqA5;
    words[1] = 8'h01; seqs[1] = Seq01;
    for (int w = 0; w < 2; w++) begin
      seq = seqs[w];
      @(negedge clk);
      bus.clken = 1'b1; bus.load_valid = 1'b1; bus.load_data = words[w];
      #1;
      n_checks++;
      if (bus.load_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_ready_before: word %h got %b want 1", words[w], bus.load_ready);
      end
      @(negedge clk);
      bus.load_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.so_valid, bus.load_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL basic_latency: word %h got so_valid/load_ready=%b want 00",
                 words[w], {bus.so_valid, bus.load_ready});
      end
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.SO, bus.so_valid, bus.done} !== {seq[7-i], 1'b1, (i == 7)}) begin
          n_fail++;
          $display("FAIL basic_bit: word %h bit %0d got SO/so_valid/done=%b want %b",
                   words[w], i, {bus.SO, bus.so_valid, bus.done}, {seq[7-i], 1'b1, (i == 7)});
        end
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.SO, bus.so_valid, bus.done, bus.load_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL basic_idle_after: word %h got %b want 0001", words[w],
                 {bus.SO, bus.so_valid, bus.done, bus.load_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    int          dones;
    seq   = {SeqF0, Seq0F};
    dones = 0;
    @(negedge clk);
    bus.clken = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'hF0;
    @(negedge clk);
    bus.load_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) bus.load_valid = 1'b0;
      #1;
      if (bus.done === 1'b1) dones++;
      n_checks++;
      if ({bus.SO, bus.so_valid, bus.done} !== {seq[15-i], 1'b1, (i == 7 || i == 15)}) begin
        n_fail++;
        $display("FAIL b2b_bit: bit %0d got SO/so_valid/done=%b want %b", i,
                 {bus.SO, bus.so_valid, bus.done}, {seq[15-i], 1'b1, (i == 7 || i == 15)});
      end
    end
    n_checks++;
    if (dones != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 2", dones);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.so_valid, bus.load_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_idle_after: got so_valid/load_ready=%b want 01",
               {bus.so_valid, bus.load_ready});
    end
  endtask

  task automatic test_clken();
    logic [7:0] seq;
    seq = Seq81;
    @(negedge clk);
    bus.clken = 1'b0; bus.load_valid = 1'b1; bus.load_data = 8'h81;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.clken = 1'b1;
    #1;
    n_checks++;
    if (bus.load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_handshake: got load_ready=%b want 0", bus.load_ready);
    end
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bus.clken = (k % 3 == 2);
      #1;
      n_checks++;
      if ({bus.SO, bus.so_valid, bus.done} !== {seq[7-(k/3)], 1'b1, (k == 23)}) begin
        n_fail++;
        $display("FAIL clken_bit: cycle %0d got SO/so_valid/done=%b want %b", k,
                 {bus.SO, bus.so_valid, bus.done}, {seq[7-(k/3)], 1'b1, (k == 23)});
      end
    end
    @(negedge clk);
    bus.clken = 1'b1;
    #1;
    n_checks++;
    if (bus.so_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clken_idle_after: got so_valid=%b want 0", bus.so_valid);
    end
  endtask

  task automatic test_hold_full();
    logic [15:0] seq;
    seq = {SeqA5, Seq3C};
    @(negedge clk);
    bus.clken = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'hA5;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.load_valid = 1'b1; bus.load_data = 8'h3C;
      end else if (k == 1) begin
        bus.load_data = 8'h33;
      end else begin
        bus.load_valid = 1'b0;
      end
      #1;
      if (k == 1) begin
        n_checks++;
        if (bus.load_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL hold_full_ready: got load_ready=%b want 0", bus.load_ready);
        end
      end
      if (k < 16) begin
        n_checks++;
        if ({bus.SO, bus.so_valid} !== {seq[15-k], 1'b1}) begin
          n_fail++;
          $display("FAIL hold_full_bit: bit %0d got SO/so_valid=%b want %b", k,
                   {bus.SO, bus.so_valid}, {seq[15-k], 1'b1});
        end
      end else begin
        n_checks++;
        if ({bus.so_valid, bus.load_ready} !== 2'b01) begin
          n_fail++;
          $display("FAIL hold_full_dropped: got so_valid/load_ready=%b want 01",
                   {bus.so_valid, bus.load_ready});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.clken = 1'b1; bus.load_valid = 1'b1; bus.load_data = 8'hFF;
    @(negedge clk);
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.load_valid = (i == 0);
      bus.load_data  = 8'h55;
      #1;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.SO, bus.so_valid, bus.done, bus.load_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got SO/so_valid/done/load_ready=%b want 0001",
               {bus.SO, bus.so_valid, bus.done, bus.load_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
      n_checks++;
      if ({bus.so_valid, bus.load_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL reset_mid_discard: cycle %0d got so_valid/load_ready=%b want 01", i,
                 {bus.so_valid, bus.load_ready});
      end
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got %0d done pulses want 0", dones);
    end
  endtask

  initial begin
    bus.clken      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_clken();
    test_hold_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
